// File: rtl/instr_encoder.sv
// Packs decoded operands (one-hot destination, mux-select source, sign-extended
// immediate) back into 16-bit instruction words and streams them to memory.
module instr_encoder #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = 16'h03FF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic [3:0]            ext,
  input  logic                  imm_mode,
  input  logic [15:0]           rdst_onehot,
  input  logic [4:0]            rsrc_sel,
  input  logic [15:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] words_written
);

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE, ERR} state_t;

  state_t      state;
  logic [3:0]  op_q;
  logic [3:0]  ext_q;
  logic        mode_q;
  logic [15:0] rdst_q;
  logic [4:0]  rsrc_q;
  logic [15:0] imm_q;

  logic [3:0]  rdst_idx;
  logic [4:0]  rdst_cnt;
  logic [3:0]  rsrc_idx;
  logic [1:0]  err_c;
  logic [15:0] word_c;

  always_comb begin
    rdst_idx = '0;
    rdst_cnt = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (rdst_q[i]) begin
        rdst_idx = 4'(i);
        rdst_cnt = rdst_cnt + 5'd1;
      end
    end
    rsrc_idx = 4'(rsrc_q - 5'd1);

    if (rdst_cnt != 5'd1)
      err_c = 2'b01;
    else if (!mode_q && (rsrc_q == 5'd0 || rsrc_q > 5'd16))
      err_c = 2'b10;
    else if (mode_q && (imm_q[15:8] != {8{imm_q[7]}}))
      err_c = 2'b11;
    else
      err_c = 2'b00;

    word_c = mode_q ? {op_q, rdst_idx, imm_q[7:0]}
                    : {op_q, rdst_idx, ext_q, rsrc_idx};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      mem_we        <= 1'b0;
      mem_addr      <= BASE_ADDR;
      mem_data      <= '0;
      err_valid     <= 1'b0;
      err_code      <= '0;
      full          <= 1'b0;
      words_written <= '0;
      op_q          <= '0;
      ext_q         <= '0;
      mode_q        <= 1'b0;
      rdst_q        <= '0;
      rsrc_q        <= '0;
      imm_q         <= '0;
    end else if (clr) begin
      // Restart wins over any in-flight write or error pulse.
      state         <= IDLE;
      in_ready      <= 1'b1;
      mem_we        <= 1'b0;
      mem_addr      <= BASE_ADDR;
      err_valid     <= 1'b0;
      err_code      <= '0;
      full          <= 1'b0;
      words_written <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= opcode;
            ext_q    <= ext;
            mode_q   <= imm_mode;
            rdst_q   <= rdst_onehot;
            rsrc_q   <= rsrc_sel;
            imm_q    <= imm;
            in_ready <= 1'b0;
            state    <= ENCODE;
          end
        end
        ENCODE: begin
          if (err_c != 2'b00) begin
            err_valid <= 1'b1;
            err_code  <= err_c;
            state     <= ERR;
          end else begin
            mem_we   <= 1'b1;
            mem_data <= word_c;
            state    <= WRITE;
          end
        end
        WRITE: begin
          mem_we        <= 1'b0;
          words_written <= words_written + ADDR_WIDTH'(1);
          // The last address is written once; afterwards the address parks there.
          if (mem_addr == LAST_ADDR) begin
            full     <= 1'b1;
            in_ready <= 1'b0;
          end else begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            in_ready <= 1'b1;
          end
          state <= IDLE;
        end
        ERR: begin
          err_valid <= 1'b0;
          err_code  <= '0;
          in_ready  <= ~full;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance plus a three-word
// instance for the full/clr behaviour, both driven from the same operands.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic        in_valid;
  logic [3:0]  opcode;
  logic [3:0]  ext;
  logic        imm_mode;
  logic [15:0] rdst_onehot;
  logic [4:0]  rsrc_sel;
  logic [15:0] imm;

  logic        in_ready, mem_we, err_valid, full;
  logic [15:0] mem_addr, mem_data, words_written;
  logic [1:0]  err_code;

  logic        f_in_ready, f_mem_we, f_err_valid, f_full;
  logic [15:0] f_mem_addr, f_mem_data, f_words_written;
  logic [1:0]  f_err_code;

  int n_total = 0;
  int n_bad   = 0;
  int f_writes = 0;
  logic [15:0] exp_addr  = '0;
  logic [15:0] exp_words = '0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .ext(ext), .imm_mode(imm_mode), .rdst_onehot(rdst_onehot),
    .rsrc_sel(rsrc_sel), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .err_valid(err_valid), .err_code(err_code), .full(full),
    .words_written(words_written)
  );

  instr_encoder #(.LAST_ADDR(16'h0002)) dut_f (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(f_in_ready),
    .opcode(opcode), .ext(ext), .imm_mode(imm_mode), .rdst_onehot(rdst_onehot),
    .rsrc_sel(rsrc_sel), .imm(imm), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
    .mem_data(f_mem_data), .err_valid(f_err_valid), .err_code(f_err_code), .full(f_full),
    .words_written(f_words_written)
  );

  always @(posedge clk) if (f_mem_we) f_writes <= f_writes + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input logic [3:0] op, input logic [3:0] ex, input logic md,
                         input logic [15:0] rd, input logic [4:0] rs, input logic [15:0] im);
    opcode = op; ext = ex; imm_mode = md; rdst_onehot = rd; rsrc_sel = rs; imm = im;
  endtask

  task automatic scramble();
    set_ops(4'hE, 4'h9, ~imm_mode, 16'h0C00, 5'd31, 16'h5A5A);
  endtask

  // Called and returns at a falling edge.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", in_ready, 1);
  endtask

  // One complete operation; exp_err==0 means a write of exp_word is expected.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] ex,
                        input logic md, input logic [15:0] rd, input logic [4:0] rs,
                        input logic [15:0] im, input logic [1:0] exp_err,
                        input logic [15:0] exp_word);
    wait_ready();
    set_ops(op, ex, md, rd, rs, im);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    scramble();
    @(negedge clk);
    chk({tag, "_busy"}, in_ready, 0);
    chk({tag, "_we0"}, mem_we, 0);
    @(negedge clk);
    if (exp_err == 2'b00) begin
      chk({tag, "_we"}, mem_we, 1);
      chk({tag, "_addr"}, mem_addr, exp_addr);
      chk({tag, "_data"}, mem_data, exp_word);
      chk({tag, "_noerr"}, err_valid, 0);
    end else begin
      chk({tag, "_errv"}, err_valid, 1);
      chk({tag, "_code"}, err_code, exp_err);
      chk({tag, "_nowe"}, mem_we, 0);
      chk({tag, "_addr"}, mem_addr, exp_addr);
    end
    @(negedge clk);
    if (exp_err == 2'b00) begin
      exp_addr++;
      exp_words++;
    end
    chk({tag, "_we_end"}, mem_we, 0);
    chk({tag, "_err_end"}, {err_valid, err_code}, 0);
    chk({tag, "_addr_next"}, mem_addr, exp_addr);
    chk({tag, "_words"}, words_written, exp_words);
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    in_valid = 1'b0;
    exp_addr = '0;
    exp_words = '0;
  endtask

  logic [3:0]  bb_op[4], bb_ext[4];
  logic        bb_md[4];
  logic [15:0] bb_rd[4], bb_im[4], bb_word[4];
  logic [4:0]  bb_rs[4];

  initial begin
    bb_op = '{4'h2, 4'h9, 4'hF, 4'h4};
    bb_ext = '{4'h3, 4'h0, 4'hF, 4'h0};
    bb_md = '{1'b0, 1'b1, 1'b0, 1'b1};
    bb_rd = '{16'h0020, 16'h0400, 16'h0100, 16'h0001};
    bb_rs = '{5'd9, 5'd0, 5'd11, 5'd0};
    bb_im = '{16'h0000, 16'h0012, 16'h0000, 16'hFF81};
    bb_word = '{16'h2538, 16'h9A12, 16'hF8FA, 16'h4081};

    reset = 1'b1; clr = 1'b0; in_valid = 1'b0;
    set_ops('0, '0, 1'b0, '0, '0, '0);
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_data", mem_data, 16'h0000);
    chk("rst_err", {err_valid, err_code}, 0);
    chk("rst_full", full, 0);
    chk("rst_words", words_written, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("reg", 4'h0, 4'h5, 1'b0, 16'h0008, 5'd6, 16'h1234, 2'b00, 16'h0355);
    run_op("imm_neg", 4'h5, 4'hA, 1'b1, 16'h0002, 5'd0, 16'hFFF6, 2'b00, 16'h51F6);
    run_op("imm_pos", 4'h5, 4'h0, 1'b1, 16'h8000, 5'd3, 16'h007F, 2'b00, 16'h5F7F);

    chk("f_full", f_full, 1);
    chk("f_ready", f_in_ready, 0);
    chk("f_addr_hold", f_mem_addr, 16'h0002);
    chk("f_words", f_words_written, 3);

    run_op("rsrc16", 4'hA, 4'hC, 1'b0, 16'h0001, 5'd16, 16'h0000, 2'b00, 16'hA0CF);
    chk("f_ignored", f_writes, 3);
    chk("f_words_hold", f_words_written, 3);

    // clr with in_valid high in the same cycle: no accept.
    set_ops(4'h3, 4'h3, 1'b0, 16'h0002, 5'd2, 16'h0000);
    in_valid = 1'b1;
    pulse_clr();
    @(negedge clk);
    chk("clr_ready", in_ready, 1);
    chk("clr_addr", mem_addr, 16'h0000);
    chk("clr_words", words_written, 0);
    chk("clr_f_full", f_full, 0);
    chk("clr_f_ready", f_in_ready, 1);
    chk("clr_f_addr", f_mem_addr, 16'h0000);
    @(negedge clk);
    chk("clr_no_accept", in_ready, 1);

    run_op("rsrc1", 4'h1, 4'h0, 1'b0, 16'h4000, 5'd1, 16'hFFFF, 2'b00, 16'h1E00);
    chk("f_after_clr_words", f_words_written, 1);

    run_op("e_two", 4'h1, 4'h0, 1'b0, 16'h0011, 5'd2, 16'h0000, 2'b01, 16'h0000);
    run_op("e_zero", 4'h1, 4'h0, 1'b1, 16'h0000, 5'd2, 16'h0000, 2'b01, 16'h0000);
    run_op("e_rs0", 4'h1, 4'h0, 1'b0, 16'h0004, 5'd0, 16'h0000, 2'b10, 16'h0000);
    run_op("e_rs17", 4'h1, 4'h0, 1'b0, 16'h0004, 5'd17, 16'h0000, 2'b10, 16'h0000);
    run_op("e_imm80", 4'h1, 4'h0, 1'b1, 16'h0004, 5'd2, 16'h0080, 2'b11, 16'h0000);
    run_op("e_immff7f", 4'h1, 4'h0, 1'b1, 16'h0004, 5'd2, 16'hFF7F, 2'b11, 16'h0000);
    run_op("e_both", 4'h1, 4'h0, 1'b0, 16'h0000, 5'd0, 16'h0000, 2'b01, 16'h0000);
    run_op("imm_min", 4'h7, 4'h0, 1'b1, 16'h0010, 5'd0, 16'hFF80, 2'b00, 16'h7480);

    // clr during the encode cycle aborts the pending write.
    wait_ready();
    set_ops(4'h6, 4'h1, 1'b0, 16'h0002, 5'd3, 16'h0000);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    pulse_clr();
    @(negedge clk);
    chk("clrenc_we", mem_we, 0);
    chk("clrenc_addr", mem_addr, 16'h0000);
    chk("clrenc_words", words_written, 0);
    @(negedge clk);
    chk("clrenc_we_later", mem_we, 0);
    chk("clrenc_ready", in_ready, 1);

    // clr while the write strobe is up: no count, address back to base.
    set_ops(4'h6, 4'h1, 1'b0, 16'h0002, 5'd3, 16'h0000);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("clrwr_we_up", mem_we, 1);
    pulse_clr();
    @(negedge clk);
    chk("clrwr_we", mem_we, 0);
    chk("clrwr_words", words_written, 0);
    chk("clrwr_addr", mem_addr, 16'h0000);

    // Back-to-back with in_valid held; next operands appear right after each accept.
    wait_ready();
    set_ops(bb_op[0], bb_ext[0], bb_md[0], bb_rd[0], bb_rs[0], bb_im[0]);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) set_ops(bb_op[i+1], bb_ext[i+1], bb_md[i+1], bb_rd[i+1], bb_rs[i+1], bb_im[i+1]);
      else begin
        in_valid = 1'b0;
        scramble();
      end
      @(negedge clk);
      chk("bb_busy", in_ready, 0);
      @(negedge clk);
      chk("bb_we", mem_we, 1);
      chk("bb_addr", mem_addr, exp_addr);
      chk("bb_data", mem_data, bb_word[i]);
      @(negedge clk);
      exp_addr++;
      exp_words++;
      chk("bb_we_end", mem_we, 0);
      chk("bb_words", words_written, exp_words);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bb_idle_we", mem_we, 0);
    end
    chk("bb_total", words_written, 4);

    // Asynchronous reset in the middle of encode.
    set_ops(4'h2, 4'h3, 1'b0, 16'h0020, 5'd9, 16'h0000);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_ready", in_ready, 1);
    chk("arst_addr", mem_addr, 16'h0000);
    chk("arst_data", mem_data, 16'h0000);
    chk("arst_words", words_written, 0);
    chk("arst_flags", {mem_we, err_valid, err_code, full}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_lost", mem_we, 0);
    end
    chk("arst_words_after", words_written, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the register/immediate decode stage: takes the decoded form of an instruction and packs it back into a 16-bit instruction word.
  - Destination: 16-bit one-hot write enable.
  - Source: 5-bit register-file mux select (index+1).
  - Immediate: 16-bit sign-extended value.
- Validates each field and writes legal words to instruction memory at an auto-incrementing address.
- Used by the bench/loader path and self-modifying test harnesses to build program images from decoded operands.

Parameters:
- ADDR_WIDTH, 16, width of mem_addr and word counter.
- BASE_ADDR, 16'h0000, first memory address written after reset/clr.
- LAST_ADDR, 16'h03FF, last writable address; a write here sets full.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous restart: address back to BASE_ADDR, flags cleared.
- in_valid  in  1  operand set presented.
- in_ready  out  1  encoder can accept operands.
- opcode  in  4  instruction bits [15:12].
- ext  in  4  opcode extension, bits [7:4] (register form only).
- imm_mode  in  1  1 = immediate form, 0 = register form.
- rdst_onehot  in  16  one-hot destination, bit n = rn.
- rsrc_sel  in  5  source mux select, 1..16 = r0..r15.
- imm  in  16  sign-extended immediate.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  16  encoded instruction word.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  01 bad rdst, 10 bad rsrc, 11 imm out of range; 00 otherwise.
- full  out  1  LAST_ADDR has been written.
- words_written  out  ADDR_WIDTH  count of successful writes since reset/clr.

Behaviour:
- Reset values (async, immediate):
  - state IDLE; in_ready=1.
  - mem_we=0, mem_addr=BASE_ADDR, mem_data=0.
  - err_valid=0, err_code=00, full=0, words_written=0.
- All outputs are registered.
- States:
  - IDLE: in_ready = ~full. On in_valid & in_ready, latch all inputs and go to ENCODE.
  - ENCODE: in_ready=0. Compute the rdst index, rsrc index and error.
    - Error: go to ERR.
    - No error: go to WRITE.
  - WRITE: mem_we=1 for exactly this cycle, with mem_addr=current address and mem_data=word.
    - Next edge: address+1 (or full=1 if address==LAST_ADDR; address then holds), words_written+1, return to IDLE.
  - ERR: err_valid=1, err_code held for this cycle. No write; address and count unchanged. Next edge: IDLE, err_code back to 00.
- Latency: accept at edge 0, mem_we high from edge 1 to edge 2, in_ready high again after edge 2. One word per 3 cycles max.
- Encoding:
  - Register form: {opcode, rdst_idx, ext, rsrc_idx}.
  - Immediate form: {opcode, rdst_idx, imm[7:0]}; ext and rsrc_sel are ignored.
- Field checks, in priority order:
  - rdst_onehot must have exactly one bit set, else 01.
  - Register form: rsrc_sel must be 1..16, else 10; rsrc_idx = rsrc_sel-1.
  - Immediate form: imm[15:8] must equal all copies of imm[7], else 11.
- Inputs are sampled only at the accept edge; changes afterward have no effect.
- full:
  - Once set, in_ready=0 and in_valid is ignored.
  - Cleared only by clr or reset.
- clr:
  - Takes priority over everything in any state; returns to IDLE.
  - A pending WRITE is aborted: mem_we stays 0 that cycle. A pending ERR pulse is suppressed.
  - Address = BASE_ADDR, words_written=0, full=0, err_code=00.
  - in_valid in the clr cycle is not accepted.
- Reset mid-operation: immediate return to reset values; the word in flight is lost.

Test Plan:
- Register form: opcode=0, ext=5, rdst_onehot=16'h0008, rsrc_sel=6 -> mem_we pulse at addr 0x0000, mem_data=16'h0355, words_written=1, in_ready back 3 cycles after accept.
- Immediate form: opcode=5, rdst_onehot=16'h0002, imm=16'hFFF6 -> mem_data=16'h51F6 at 0x0001. Then imm=16'h007F, rdst 16'h8000 -> 16'h5F7F at 0x0002.
- Errors:
  - rdst_onehot=16'h0011 -> err_code 01.
  - rdst_onehot=0 -> err_code 01.
  - rsrc_sel=0 -> err_code 10; rsrc_sel=17 -> err_code 10.
  - imm=16'h0080 (imm_mode=1) -> err_code 11.
  - Each: one-cycle err_valid, no mem_we, address unchanged.
  - Bad rdst plus bad rsrc together -> 01.
- Full: LAST_ADDR=BASE_ADDR+2, three legal writes -> full=1 after the third, in_ready=0. A fourth in_valid is ignored. clr -> full=0, next write at BASE_ADDR.
- clr asserted during WRITE -> mem_we stays 0, words_written=0. Reset asserted mid-ENCODE -> all outputs at reset values without waiting for a clock edge.
- Back-to-back: in_valid held high with 4 operand sets -> exactly 4 writes at consecutive addresses, 3-cycle spacing. Operand changes after the accept edge are not reflected in mem_data.
